neuron_backprop: RTL and testbench
==================================

Name: neuron_backprop

Overview:
- Backward-pass partner of the two-input Q16.16 forward neuron (bias b, weights w1/w2).
- Owns the neuron's w1, w2 and b registers and drives them to the forward neuron.
- Per training sample, takes inputs x1/x2, upstream gradient grad and learning rate lr.
- Produces input gradients dx1/dx2 for the previous layer, then applies an SGD update to w1, w2, b.
- Uses one shared 32x32 signed multiplier, sequenced by an FSM.

Parameters:
- W1_INIT, 32'sd32768, reset value of w1 (0.5 in Q16.16)
- W2_INIT, 32'sd22937, reset value of w2 (about 0.35)
- B_INIT, 32'sd32768, reset value of b (0.5)
- FRAC, 16, fractional bits of the fixed-point format

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- load_en  in  1  load w1/b/w2 from ld_w1/ld_w2/ld_b; honoured only in IDLE
- ld_w1, ld_w2, ld_b  in  32 each  signed Q16.16 load values
- in_valid  in  1  sample valid
- in_ready  out  1  high only in IDLE
- x1, x2  in  32  signed Q16.16 forward inputs of the sample
- grad  in  32  signed Q16.16 dL/dy for the neuron output
- lr  in  32  signed Q16.16 learning rate
- out_valid  out  1  dx results valid
- out_ready  in  1  consumer accepts dx results
- dx1, dx2  out  32  signed Q16.16 gradients w.r.t. x1, x2
- w1, w2, b  out  32  signed Q16.16 current parameters, registered

Behaviour:
- **Reset** (rst_n low, any time, async): state=IDLE, w1/w2/b=W*_INIT/B_INIT, dx1/dx2=0, out_valid=0, in_ready=1. An in-flight sample is discarded; no partial weight update persists.
- **Fixed-point multiply** mul(a,c): 64-bit signed product, arithmetic shift right FRAC (floor toward -inf), keep low 32 bits (wrap).
- **Add/sub**: 32-bit two's complement, wrap, unless the optional feature is enabled.
- **Capture**: on an edge with in_valid&&in_ready, latch x1, x2, grad, lr; go to SCALE.
- **States** (one cycle each unless noted):
  - IDLE: in_ready=1. load_en loads w1/w2/b from ld_*. If load_en and in_valid are both high, the load happens and the sample is still accepted; the new weights are used.
  - SCALE: g <= mul(lr, grad).
  - DX1: dx1 <= mul(grad, w1) using the pre-update w1.
  - DX2: dx2 <= mul(grad, w2) using the pre-update w2.
  - UPDW1: w1 <= w1 - mul(g, x1); b <= b - g.
  - UPDW2: w2 <= w2 - mul(g, x2).
  - DONE: out_valid=1; stays until out_ready is high on an edge, then goes to IDLE. Hold dx1/dx2 stable while waiting.
- **Latency**: out_valid rises exactly 5 cycles after the accept edge. Minimum throughput is one sample per 7 cycles (out_ready tied high).
- **Weights**:
  - w1/w2/b change only in UPDW1/UPDW2 or on a load in IDLE.
  - w1 and b update together; w2 updates one cycle later.
  - The forward neuron must not sample w1/w2/b between UPDW1 and DONE.
- in_valid outside IDLE is ignored (in_ready=0); load_en outside IDLE is ignored.
- lr=0 or grad=0: dx and weights follow the formulas (weights unchanged when g=0); no special path.

Optional Feature:
- **Macro**: BACKPROP_SATURATE_EN.
- **Defined**:
  - Every mul result that exceeds the signed 32-bit range clamps to 32'h7FFFFFFF / 32'h80000000.
  - Every add/sub likewise clamps instead of wrapping.
- **Undefined**: pure wrap-around as above; no extra logic.

Test Plan:
- **Reset values**: assert rst_n=0 mid-DX2, release -> w1=32768, w2=22937, b=32768, out_valid=0, in_ready=1 next cycle, no update applied.
- **Nominal update**: defaults, sample x1=32768, x2=-32768, grad=65536, lr=32768 -> after 5 cycles dx1=32768, dx2=22937; final w1=16384, w2=39321, b=0.
- **Backpressure**: out_ready=0 for 10 cycles in DONE -> out_valid, dx1, dx2 stable, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle, then back-to-back sample accepted.
- **Load**: load_en in IDLE with ld_w1=-65536, ld_w2=0, ld_b=0 -> registers updated. load_en during DX1 -> ignored.
- **Overflow**: load w1=32'h7FFF0000; sample grad=131072, lr=0 -> dx1=32'hFFFE0000 without macro, 32'h7FFFFFFF with BACKPROP_SATURATE_EN; weights unchanged.
- **Negative floor**: load w1=-1 (32'hFFFFFFFF), grad=1 -> dx1=32'hFFFFFFFF (floor), not 0.

Source files
------------

// File: rtl/neuron_backprop.sv
// rtl/neuron_backprop.sv - backward pass and SGD update for a two-input Q16.16 neuron
// Optional macro BACKPROP_SATURATE_EN: saturating multiply and subtract instead of wrap.
module neuron_backprop #(
  parameter logic signed [31:0] W1_INIT = 32'sd32768,
  parameter logic signed [31:0] W2_INIT = 32'sd22937,
  parameter logic signed [31:0] B_INIT  = 32'sd32768,
  parameter int                 FRAC    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic signed [31:0] ld_w1,
  input  logic signed [31:0] ld_w2,
  input  logic signed [31:0] ld_b,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] x1,
  input  logic signed [31:0] x2,
  input  logic signed [31:0] grad,
  input  logic signed [31:0] lr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] dx1,
  output logic signed [31:0] dx2,
  output logic signed [31:0] w1,
  output logic signed [31:0] w2,
  output logic signed [31:0] b
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCALE = 3'd1,
    DX1   = 3'd2,
    DX2   = 3'd3,
    UPDW1 = 3'd4,
    UPDW2 = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t state, state_next;

  logic signed [31:0] x1_q, x2_q, grad_q, lr_q, g_q;
  logic signed [31:0] mul_a, mul_b, mul_res;
  logic signed [63:0] a64, b64, prod;

  // a - c, clamped to the signed 32-bit range when saturation is built in
  function automatic logic signed [31:0] sub_op(input logic signed [31:0] a,
                                                input logic signed [31:0] c);
`ifdef BACKPROP_SATURATE_EN
    logic signed [32:0] d;
    d = {a[31], a} - {c[31], c};
    if (d[32] != d[31]) return d[32] ? 32'sh80000000 : 32'sh7FFFFFFF;
    return d[31:0];
`else
    return a - c;
`endif
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Shared multiplier: full 64-bit signed product, floor shift by FRAC
  assign a64  = mul_a;
  assign b64  = mul_b;
  assign prod = a64 * b64;

`ifdef BACKPROP_SATURATE_EN
  logic signed [63:0] prod_sh;
  assign prod_sh = prod >>> FRAC;
  // Clamp when the shifted product does not fit in 32 signed bits
  always_comb begin
    mul_res = prod_sh[31:0];
    if (prod_sh[63:31] != {33{prod_sh[63]}})
      mul_res = prod_sh[63] ? 32'sh80000000 : 32'sh7FFFFFFF;
  end
`else
  assign mul_res = 32'(prod >>> FRAC);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state sequencing and multiplier operand selection per step
  always_comb begin
    state_next = state;
    mul_a      = '0;
    mul_b      = '0;
    case (state)
      IDLE:  if (in_valid) state_next = SCALE;
      SCALE: begin mul_a = lr_q;   mul_b = grad_q; state_next = DX1;   end
      DX1:   begin mul_a = grad_q; mul_b = w1;     state_next = DX2;   end
      DX2:   begin mul_a = grad_q; mul_b = w2;     state_next = UPDW1; end
      UPDW1: begin mul_a = g_q;    mul_b = x1_q;   state_next = UPDW2; end
      UPDW2: begin mul_a = g_q;    mul_b = x2_q;   state_next = DONE;  end
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: sample capture, parameter loads, gradient results and weight updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w1     <= W1_INIT;
      w2     <= W2_INIT;
      b      <= B_INIT;
      dx1    <= '0;
      dx2    <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
      grad_q <= '0;
      lr_q   <= '0;
      g_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_en) begin
            w1 <= ld_w1;
            w2 <= ld_w2;
            b  <= ld_b;
          end
          if (in_valid) begin
            x1_q   <= x1;
            x2_q   <= x2;
            grad_q <= grad;
            lr_q   <= lr;
          end
        end
        SCALE: g_q <= mul_res;
        DX1:   dx1 <= mul_res;
        DX2:   dx2 <= mul_res;
        UPDW1: begin
          w1 <= sub_op(w1, mul_res);
          b  <= sub_op(b, g_q);
        end
        UPDW2: w2 <= sub_op(w2, mul_res);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_backprop.sv
// tb/tb_neuron_backprop.sv - directed self-checking bench for neuron_backprop
module tb_neuron_backprop;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic [31:0] ld_w1, ld_w2, ld_b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1, x2, grad, lr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dx1, dx2, w1, w2, b;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  neuron_backprop dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en),
    .ld_w1(ld_w1), .ld_w2(ld_w2), .ld_b(ld_b),
    .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .grad(grad), .lr(lr),
    .out_valid(out_valid), .out_ready(out_ready),
    .dx1(dx1), .dx2(dx2), .w1(w1), .w2(w2), .b(b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: observed %h required %h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] vx1, input logic [31:0] vx2,
                      input logic [31:0] vg, input logic [31:0] vlr);
    x1 = vx1; x2 = vx2; grad = vg; lr = vlr;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] c, input logic [31:0] d);
    ld_w1 = a; ld_w2 = c; ld_b = d;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load_en = 1'b0; ld_w1 = '0; ld_w2 = '0; ld_b = '0;
    in_valid = 1'b0; x1 = '0; x2 = '0; grad = '0; lr = '0; out_ready = 1'b1;
    tick(); tick();
    check_eq("rst_w1", w1, 32'd32768);
    check_eq("rst_w2", w2, 32'd22937);
    check_eq("rst_b", b, 32'd32768);
    check_eq("rst_dx1", dx1, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Nominal sample, held in DONE by backpressure
    out_ready = 1'b0;
    send(32'd32768, 32'hFFFF8000, 32'd65536, 32'd32768);
    wait_out(lat);
    check_eq("nom_latency", lat, 32'd5);
    check_eq("nom_dx1", dx1, 32'd32768);
    check_eq("nom_dx2", dx2, 32'd22937);
    check_eq("nom_w1", w1, 32'd16384);
    check_eq("nom_w2", w2, 32'd39321);
    check_eq("nom_b", b, 32'd0);
    x1 = 32'd65536; x2 = 32'd65536; grad = 32'd65536; lr = 32'd65536;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_dx1", dx1, 32'd32768);
      check_eq("bp_dx2", dx2, 32'd22937);
      check_eq("bp_w2", w2, 32'd39321);
    end
    out_ready = 1'b1;
    tick();
    check_eq("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    check_eq("b2b_accepted", {31'd0, in_ready}, 32'd0);

    // Asynchronous reset in the middle of DX2 of that sample
    tick(); tick();
    rst_n = 1'b0;
    #2;
    check_eq("areset_w1", w1, 32'd32768);
    check_eq("areset_w2", w2, 32'd22937);
    check_eq("areset_b", b, 32'd32768);
    check_eq("areset_dx1", dx1, 32'd0);
    check_eq("areset_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("post_rst_w1", w1, 32'd32768);
    check_eq("post_rst_w2", w2, 32'd22937);
    check_eq("post_rst_b", b, 32'd32768);

    // Load in IDLE, then a load attempt during DX1 that must be ignored
    do_load(32'hFFFF0000, 32'd0, 32'd0);
    check_eq("load_w1", w1, 32'hFFFF0000);
    check_eq("load_w2", w2, 32'd0);
    check_eq("load_b", b, 32'd0);
    send(32'd65536, 32'd65536, 32'd65536, 32'd65536);
    tick();
    do_load(32'd12345, 32'd12345, 32'd12345);
    check_eq("busy_load_ignored_w1", w1, 32'hFFFF0000);
    check_eq("busy_load_ignored_b", b, 32'd0);
    wait_out(lat);
    check_eq("ld_latency_rest", lat, 32'd3);
    check_eq("ld_dx1", dx1, 32'hFFFF0000);
    check_eq("ld_dx2", dx2, 32'd0);
    check_eq("ld_w1_upd", w1, 32'hFFFE0000);
    check_eq("ld_w2_upd", w2, 32'hFFFF0000);
    check_eq("ld_b_upd", b, 32'hFFFF0000);
    tick();

    // Overflow of grad*w1 with lr=0
    do_load(32'h7FFF0000, 32'd0, 32'd0);
    send(32'd65536, 32'd65536, 32'd131072, 32'd0);
    wait_out(lat);
    check_eq("ovf_latency", lat, 32'd5);
`ifdef BACKPROP_SATURATE_EN
    check_eq("ovf_dx1", dx1, 32'h7FFFFFFF);
`else
    check_eq("ovf_dx1", dx1, 32'hFFFE0000);
`endif
    check_eq("ovf_dx2", dx2, 32'd0);
    check_eq("ovf_w1", w1, 32'h7FFF0000);
    check_eq("ovf_w2", w2, 32'd0);
    check_eq("ovf_b", b, 32'd0);
    tick();

    // Load and accept on the same edge; floor of a negative product
    ld_w1 = 32'hFFFFFFFF; ld_w2 = 32'd0; ld_b = 32'd0;
    load_en = 1'b1;
    send(32'd65536, 32'd65536, 32'd1, 32'd0);
    load_en = 1'b0;
    wait_out(lat);
    check_eq("floor_latency", lat, 32'd5);
    check_eq("floor_dx1", dx1, 32'hFFFFFFFF);
    check_eq("floor_dx2", dx2, 32'd0);
    check_eq("floor_w1", w1, 32'hFFFFFFFF);
    tick();
    check_eq("final_in_ready", {31'd0, in_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
